// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: job request and result handshake bundle for the shift sequencer
interface shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shiftType;
    logic [7:0]  shiftAmt;
    logic [31:0] rmData;
    logic        carryIn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shiftedData;
    logic        carryOut;
    modport master (
        output in_valid, shiftType, shiftAmt, rmData, carryIn, out_ready,
        input  in_ready, out_valid, shiftedData, carryOut
    );
    modport slave (
        input  in_valid, shiftType, shiftAmt, rmData, carryIn, out_ready,
        output in_ready, out_valid, shiftedData, carryOut
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle register-amount shifter feeding ALU operand 2
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    output logic              busy,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] data_q, data_d, step_data;
    logic [1:0]  type_q, type_d;
    logic        carry_q, carry_d, step_carry;
    logic [5:0]  rem_q, rem_d, take, acc_rem;
    assign take = (rem_q < 6'(STEP)) ? rem_q : 6'(STEP);
    assign acc_rem = (bus.shiftType == 2'b11)
        ? ((bus.shiftAmt == 8'd0) ? 6'd0 : (bus.shiftAmt[4:0] == 5'd0) ? 6'd32 : {1'b0, bus.shiftAmt[4:0]})
        : ((bus.shiftAmt > 8'd33) ? 6'd33 : bus.shiftAmt[5:0]);
    // One step: up to STEP single-bit shifts, stopping once the remaining amount is used up
    always_comb begin
        step_data  = data_q;
        step_carry = carry_q;
        for (int i = 0; i < STEP; i++) begin
            if (6'(i) < rem_q) begin
                step_carry = (type_q == 2'b00) ? step_data[31] : step_data[0];
                step_data  = (type_q == 2'b00) ? {step_data[30:0], 1'b0}
                           : {(type_q == 2'b10) ? step_data[31] : (type_q == 2'b11) ? step_data[0] : 1'b0,
                              step_data[31:1]};
            end
        end
    end
    // Next-state: abort wins, then accept in IDLE, iterate in SHIFT, release on handshake in DONE
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        type_d  = type_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        if (abort) begin
            state_d = IDLE;
        end else if (state_q == IDLE && bus.in_valid) begin
            data_d  = bus.rmData;
            type_d  = bus.shiftType;
            carry_d = bus.carryIn;
            rem_d   = acc_rem;
            state_d = (acc_rem == 6'd0) ? DONE : SHIFT;
        end else if (state_q == SHIFT) begin
            data_d  = step_data;
            carry_d = step_carry;
            rem_d   = rem_q - take;
            state_d = (rem_q == take) ? DONE : SHIFT;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            type_q  <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            type_q  <= type_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.shiftedData = data_q;
    assign bus.carryOut    = carry_q;
    assign busy            = (state_q != IDLE);
endmodule
